// File: rtl/blackjack_pkg.sv
// ---------------------------------------------------------------------------
// blackjack_pkg
// Shared constants, the shuffler state encoding and the partner-index fold
// helper for the BlackJack core.
// No ports (package).
// ---------------------------------------------------------------------------
package blackjack_pkg;

   localparam int AW        = 6;   // address width and card-code width
   localparam int DECK_SIZE = 52;  // number of cards

   localparam logic [AW-1:0] LAST_IDX = AW'(DECK_SIZE - 1);
   localparam logic [AW-1:0] J_CLAMP  = 6'd52;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_INIT = 4'd1,
      S_RD_I = 4'd2,
      S_RD_J = 4'd3,
      S_LAT  = 4'd4,
      S_WR_I = 4'd5,
      S_WR_J = 4'd6,
      S_NEXT = 4'd7,
      S_DONE = 4'd8
   } state_e;

   // Nxt_Addr can return 52..63; fold those back into the deck (63 -> 11).
   function automatic logic [AW-1:0] clamp_j(input logic [AW-1:0] j);
      return (j > LAST_IDX) ? j - J_CLAMP : j;
   endfunction

endpackage

// File: rtl/deck_shuffler.sv
// ---------------------------------------------------------------------------
// deck_shuffler
// Runs one Fisher-Yates style shuffle pass over an external 64x6
// synchronous-read deck RAM. For every index i = 0..51 it presents i to
// Nxt_Addr, takes the partner index j back, reads card[i] and card[j], then
// writes them back swapped. Six cycles per index.
//
// Build option: define DECK_INIT_EN to have each pass first rewrite the deck
// as the ordered sequence 0..51 (52 extra cycles); without it a pass permutes
// whatever the RAM already holds.
//
// Ports:
//   clk_2K       in   system clock
//   i_Reset      in   asynchronous reset, active-high
//   i_Start      in   start one pass (only honoured in IDLE)
//   o_Addr_i     out  current index i, to Nxt_Addr
//   i_Addr_j     in   partner index from Nxt_Addr
//   o_RamAddr    out  deck RAM address
//   o_RamWrData  out  deck RAM write data
//   o_RamWe      out  deck RAM write enable
//   i_RamRdData  in   deck RAM read data, one cycle after o_RamAddr
//   o_Busy       out  high whenever not IDLE
//   o_Done       out  one-cycle pulse at the end of a pass
// ---------------------------------------------------------------------------
module deck_shuffler
   import blackjack_pkg::*;
(
   input  logic          clk_2K,
   input  logic          i_Reset,
   input  logic          i_Start,
   output logic [AW-1:0] o_Addr_i,
   input  logic [AW-1:0] i_Addr_j,
   output logic [AW-1:0] o_RamAddr,
   output logic [AW-1:0] o_RamWrData,
   output logic          o_RamWe,
   input  logic [AW-1:0] i_RamRdData,
   output logic          o_Busy,
   output logic          o_Done
);

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q,   idx_d;    // also the card counter k during INIT
   logic [AW-1:0] r_j_q,   r_j_d;
   logic [AW-1:0] r_ci_q,  r_ci_d;
   logic [AW-1:0] r_cj_q,  r_cj_d;

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values, regardless of statement order.
   always_ff @(posedge clk_2K or posedge i_Reset) begin
      if (i_Reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         r_j_q   <= '0;
         r_ci_q  <= '0;
         r_cj_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         r_j_q   <= r_j_d;
         r_ci_q  <= r_ci_d;
         r_cj_q  <= r_cj_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path through
      // it leaves a value unassigned, which would infer a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      r_j_d       = r_j_q;
      r_ci_d      = r_ci_q;
      r_cj_d      = r_cj_q;
      o_RamAddr   = '0;
      o_RamWrData = '0;
      o_RamWe     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               idx_d = '0;
`ifdef DECK_INIT_EN
               state_d = S_INIT;
`else
               state_d = S_RD_I;
`endif
            end
         end
`ifdef DECK_INIT_EN
         S_INIT: begin
            o_RamAddr   = idx_q;
            o_RamWrData = idx_q;
            o_RamWe     = 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = S_RD_I;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
`endif
         S_RD_I: begin
            o_RamAddr = idx_q;
            r_j_d     = clamp_j(i_Addr_j);
            state_d   = S_RD_J;
         end
         S_RD_J: begin
            o_RamAddr = r_j_q;
            r_ci_d    = i_RamRdData;   // card[i], addressed in RD_I
            state_d   = S_LAT;
         end
         S_LAT: begin
            r_cj_d  = i_RamRdData;     // card[j], addressed in RD_J
            state_d = S_WR_I;
         end
         S_WR_I: begin
            o_RamAddr   = idx_q;
            o_RamWrData = r_cj_q;
            o_RamWe     = 1'b1;
            state_d     = S_WR_J;
         end
         S_WR_J: begin
            o_RamAddr   = r_j_q;
            o_RamWrData = r_ci_q;
            o_RamWe     = 1'b1;
            state_d     = S_NEXT;
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 6'd1;
               state_d = S_RD_I;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign o_Addr_i = idx_q;
   assign o_Busy   = (state_q != S_IDLE);
   assign o_Done   = (state_q == S_DONE);

endmodule

// File: tb/tb_deck_shuffler.sv
// ---------------------------------------------------------------------------
// tb_deck_shuffler
// Directed bench for deck_shuffler with a behavioural 64x6 synchronous-read
// deck RAM and a selectable partner-index source (tied to o_Addr_i, a
// constant, or a pseudo-random Nxt_Addr stand-in).
// ---------------------------------------------------------------------------
module tb_deck_shuffler;
   import blackjack_pkg::*;

`ifdef DECK_INIT_EN
   localparam int DONE_CYC = 365;
   localparam int INIT_W   = 52;
   localparam bit PRE_JUNK = 1'b1;   // INIT must overwrite this
`else
   localparam int DONE_CYC = 313;
   localparam int INIT_W   = 0;
   localparam bit PRE_JUNK = 1'b0;   // start from the ordered deck
`endif

   logic          clk_2K;
   logic          i_Reset;
   logic          i_Start;
   logic [AW-1:0] o_Addr_i;
   logic [AW-1:0] i_Addr_j;
   logic [AW-1:0] o_RamAddr;
   logic [AW-1:0] o_RamWrData;
   logic          o_RamWe;
   logic [AW-1:0] i_RamRdData;
   logic          o_Busy;
   logic          o_Done;

   int n_checks = 0;
   int n_errors = 0;

   int            j_mode;     // 0: tie to o_Addr_i, 1: const_j, 2: random
   logic [AW-1:0] const_j;
   logic [AW-1:0] rand_j;
   logic          preload_req;
   logic          preload_junk;
   logic [AW-1:0] mem [64];

   deck_shuffler dut (
      .clk_2K      (clk_2K),
      .i_Reset     (i_Reset),
      .i_Start     (i_Start),
      .o_Addr_i    (o_Addr_i),
      .i_Addr_j    (i_Addr_j),
      .o_RamAddr   (o_RamAddr),
      .o_RamWrData (o_RamWrData),
      .o_RamWe     (o_RamWe),
      .i_RamRdData (i_RamRdData),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done)
   );

   initial clk_2K = 1'b0;
   always #5 clk_2K = ~clk_2K;

   always @(posedge clk_2K) rand_j <= 6'($urandom_range(0, 63));

   always_comb begin
      case (j_mode)
         0:       i_Addr_j = o_Addr_i;
         1:       i_Addr_j = const_j;
         default: i_Addr_j = rand_j;
      endcase
   end

   // Deck RAM model: read returns the pre-write contents (read-before-write).
   always @(posedge clk_2K) begin
      if (preload_req) begin
         for (int k = 0; k < 64; k++)
            mem[k] <= preload_junk ? 6'(63 - k) : 6'(k);
      end else if (o_RamWe) begin
         mem[o_RamAddr] <= o_RamWrData;
      end
      i_RamRdData <= mem[o_RamAddr];
   end

   task automatic preload();
      @(negedge clk_2K) preload_req = 1'b1;
      @(negedge clk_2K) preload_req = 1'b0;
   endtask

   // Pulses i_Start for edge 0 and returns the cycle in which o_Done was
   // seen, or -1 if it never came within the budget.
   task automatic run_pass(output int done_cyc);
      int cyc;
      @(negedge clk_2K) i_Start = 1'b1;
      @(negedge clk_2K) i_Start = 1'b0;
      cyc = 1;
      while (!o_Done && cyc < 2000) begin
         @(negedge clk_2K);
         cyc++;
      end
      done_cyc = o_Done ? cyc : -1;
   endtask

   function automatic bit perm_ok();
      bit seen [DECK_SIZE];
      for (int k = 0; k < DECK_SIZE; k++) seen[k] = 1'b0;
      for (int k = 0; k < DECK_SIZE; k++) begin
         if (mem[k] > LAST_IDX) return 1'b0;
         if (seen[mem[k]]) return 1'b0;
         seen[mem[k]] = 1'b1;
      end
      return 1'b1;
   endfunction

   task automatic test_reset();
      #1;
      n_checks++;
      if (o_Busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", o_Busy); end
      n_checks++;
      if (o_Done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", o_Done); end
      n_checks++;
      if (o_RamWe !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b want 0", o_RamWe); end
      n_checks++;
      if (o_Addr_i !== 6'd0) begin n_errors++; $display("FAIL reset_addr_i got %0d want 0", o_Addr_i); end
      n_checks++;
      if (o_RamAddr !== 6'd0) begin n_errors++; $display("FAIL reset_ramaddr got %0d want 0", o_RamAddr); end
      @(negedge clk_2K) i_Reset = 1'b0;
   endtask

   task automatic test_identity();
      int dc;
      j_mode = 0;
      preload_junk = PRE_JUNK;
      preload();
      run_pass(dc);
      n_checks++;
      if (dc !== DONE_CYC) begin n_errors++; $display("FAIL identity_done_cycle got %0d want %0d", dc, DONE_CYC); end
      for (int k = 0; k < DECK_SIZE; k++) begin
         n_checks++;
         if (mem[k] !== 6'(k)) begin n_errors++; $display("FAIL identity_ram[%0d] got %0d want %0d", k, mem[k], k); end
      end
   endtask

   // j fixed at 0: card i moves to slot i+1 and the last card lands in slot 0.
   task automatic test_fixed_j();
      int dc;
      j_mode  = 1;
      const_j = 6'd0;
      preload_junk = PRE_JUNK;
      preload();
      run_pass(dc);
      n_checks++;
      if (dc !== DONE_CYC) begin n_errors++; $display("FAIL fixedj_done_cycle got %0d want %0d", dc, DONE_CYC); end
      n_checks++;
      if (mem[0] !== 6'd51) begin n_errors++; $display("FAIL fixedj_ram[0] got %0d want 51", mem[0]); end
      for (int k = 1; k < DECK_SIZE; k++) begin
         n_checks++;
         if (mem[k] !== 6'(k - 1)) begin n_errors++; $display("FAIL fixedj_ram[%0d] got %0d want %0d", k, mem[k], k - 1); end
      end
   endtask

   // Follows the first swap cycle by cycle, then aborts the pass with reset.
   task automatic test_clamp(input logic [AW-1:0] j_in, input logic [AW-1:0] j_exp);
      j_mode  = 1;
      const_j = j_in;
      @(negedge clk_2K) i_Start = 1'b1;
      @(negedge clk_2K) i_Start = 1'b0;
      for (int cyc = 1; cyc <= INIT_W + 5; cyc++) begin
         if (cyc == INIT_W + 2) begin
            n_checks++;
            if (o_RamAddr !== j_exp) begin n_errors++; $display("FAIL clamp%0d_rdj_addr got %0d want %0d", j_in, o_RamAddr, j_exp); end
         end
         if (cyc == INIT_W + 3) begin
            n_checks++;
            if (o_RamWe !== 1'b0) begin n_errors++; $display("FAIL clamp%0d_lat_we got %b want 0", j_in, o_RamWe); end
         end
         if (cyc == INIT_W + 4) begin
            n_checks++;
            if (o_RamWe !== 1'b1 || o_RamAddr !== 6'd0) begin
               n_errors++; $display("FAIL clamp%0d_wri got we=%b addr=%0d want we=1 addr=0", j_in, o_RamWe, o_RamAddr);
            end
         end
         if (cyc == INIT_W + 5) begin
            n_checks++;
            if (o_RamWe !== 1'b1 || o_RamAddr !== j_exp) begin
               n_errors++; $display("FAIL clamp%0d_wrj got we=%b addr=%0d want we=1 addr=%0d", j_in, o_RamWe, o_RamAddr, j_exp);
            end
         end
         @(negedge clk_2K);
      end
      i_Reset = 1'b1;
      @(negedge clk_2K) i_Reset = 1'b0;
   endtask

   // Random partner indices, two requested passes, extra i_Start pulses while busy.
   task automatic test_back_to_back();
      int starts = 0;
      int dones  = 0;
      int cyc    = 0;
      j_mode = 2;
      preload_junk = 1'b0;
      preload();
      while (cyc < 2 * DONE_CYC + 100) begin
         @(negedge clk_2K);
         cyc++;
         if (o_Done) begin
            dones++;
            n_checks++;
            if (!perm_ok()) begin n_errors++; $display("FAIL chain_perm pass %0d is not a permutation of 0..51", dones); end
         end
         if (!o_Busy && starts < 2) begin
            i_Start = 1'b1;
            starts++;
         end else if (o_Busy && (cyc % 37) == 0) begin
            i_Start = 1'b1;
         end else begin
            i_Start = 1'b0;
         end
      end
      i_Start = 1'b0;
      n_checks++;
      if (dones !== 2) begin n_errors++; $display("FAIL chain_done_count got %0d want 2", dones); end
   endtask

   task automatic test_abort();
      int dc;
      j_mode = 0;
      @(negedge clk_2K) i_Start = 1'b1;
      @(negedge clk_2K) i_Start = 1'b0;
      for (int cyc = 1; cyc < 100; cyc++) @(negedge clk_2K);
      n_checks++;
      if (o_Busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_before got %b want 1", o_Busy); end
      i_Reset = 1'b1;
      #1;
      n_checks++;
      if (o_Busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", o_Busy); end
      n_checks++;
      if (o_RamWe !== 1'b0 || o_Done !== 1'b0) begin n_errors++; $display("FAIL abort_we_done got we=%b done=%b want 0 0", o_RamWe, o_Done); end
      n_checks++;
      if (o_Addr_i !== 6'd0 || o_RamAddr !== 6'd0) begin
         n_errors++; $display("FAIL abort_addr got addr_i=%0d ramaddr=%0d want 0 0", o_Addr_i, o_RamAddr);
      end
      @(negedge clk_2K);
      @(negedge clk_2K) i_Reset = 1'b0;
      run_pass(dc);
      n_checks++;
      if (dc !== DONE_CYC) begin n_errors++; $display("FAIL abort_restart_done got %0d want %0d", dc, DONE_CYC); end
      @(negedge clk_2K);
      n_checks++;
      if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin n_errors++; $display("FAIL abort_idle_after got busy=%b done=%b want 0 0", o_Busy, o_Done); end
   endtask

   initial begin
      i_Reset      = 1'b1;
      i_Start      = 1'b0;
      j_mode       = 0;
      const_j      = '0;
      preload_req  = 1'b0;
      preload_junk = 1'b0;
      test_reset();
      test_identity();
      test_fixed_j();
      test_clamp(6'd60, 6'd8);
      test_clamp(6'd63, 6'd11);
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
